// File: rtl/operand_sequencer.sv
// Operand-fetch control sequencer: latches decoded addressing fields and walks the
// MSP430 addressing modes, driving fetch-mux controls and register-file read selects.
module operand_sequencer #(
  parameter logic [3:0] PC_REG = 4'd0,
  parameter logic [3:0] SR_REG = 4'd2,
  parameter logic [3:0] CG_REG = 4'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] fmt,
  input  logic [1:0] As,
  input  logic       Ad,
  input  logic       BW,
  input  logic [3:0] Rs,
  input  logic [3:0] Rd,
  output logic       busy,
  output logic       done,
  output logic [3:0] rsrc_sel,
  output logic [3:0] rdst_sel,
  output logic       srcM,
  output logic       srcL,
  output logic       dstM,
  output logic       dstL,
  output logic [1:0] AddrM,
  output logic       AddrL,
  output logic       IdxM,
  output logic       pc_inc,
  output logic       reg_inc,
  output logic [3:0] inc_sel,
  output logic [1:0] inc_amt
);

  typedef enum logic [2:0] {
    StIdle, StSrcExt, StSrcRd, StSrcInd, StDstExt, StDstRd, StDstInd, StDone
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] fmt_q, fmt_d, as_q, as_d;
  logic       ad_q, ad_d, bw_q, bw_d;
  logic [3:0] rs_q, rs_d, rd_q, rd_d;

  logic       busy_q, busy_d, done_q, done_d;
  logic [3:0] rsrc_q, rsrc_d, rdst_q, rdst_d;
  logic       srcm_q, srcm_d, srcl_q, srcl_d, dstm_q, dstm_d, dstl_q, dstl_d;
  logic [1:0] addrm_q, addrm_d;
  logic       addrl_q, addrl_d, idxm_q, idxm_d, pcinc_q, pcinc_d, reginc_q, reginc_d;
  logic [3:0] incsel_q, incsel_d;
  logic [1:0] incamt_q, incamt_d;

  logic       accept, is_jump, is_single, src_cg, dst_cg;
  logic [1:0] dmode;
  logic [3:0] src_base, dst_base;
  state_e     src_first, dst_first;

  always_comb begin
    accept = start && (state_q == StIdle);
    fmt_d  = accept ? fmt : fmt_q;
    as_d   = accept ? As  : as_q;
    ad_d   = accept ? Ad  : ad_q;
    bw_d   = accept ? BW  : bw_q;
    rs_d   = accept ? Rs  : rs_q;
    rd_d   = accept ? Rd  : rd_q;

    is_jump   = fmt_d[1];
    is_single = (fmt_d == 2'b01);
    // Single-operand instructions apply As to Rd on the destination path.
    dmode     = is_single ? as_d : {1'b0, ad_d};
    src_cg    = (rs_d == CG_REG) || ((rs_d == SR_REG) && as_d[1]);
    dst_cg    = is_single && ((rd_d == CG_REG) || ((rd_d == SR_REG) && as_d[1]));
    src_base  = ((rs_d == SR_REG) && (as_d == 2'b01)) ? CG_REG : rs_d;
    dst_base  = ((rd_d == SR_REG) && (dmode == 2'b01)) ? CG_REG : rd_d;

    if (dst_cg || (dmode == 2'b00))  dst_first = StDone;
    else if (dmode == 2'b01)         dst_first = StDstExt;
    else                             dst_first = StDstInd;

    if ((as_d == 2'b00) || src_cg)   src_first = dst_first;
    else if (as_d == 2'b01)          src_first = StSrcExt;
    else                             src_first = StSrcInd;

    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_jump)        state_d = StDone;
          else if (is_single) state_d = dst_first;
          else                state_d = src_first;
        end
      end
      StSrcExt: state_d = StSrcRd;
      StSrcRd,
      StSrcInd: state_d = dst_first;
      StDstExt: state_d = StDstRd;
      StDstRd,
      StDstInd: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    rsrc_d   = rs_d;
    rdst_d   = rd_d;
    srcm_d   = accept ? 1'b0 : srcm_q;
    dstm_d   = accept ? 1'b0 : dstm_q;
    srcl_d   = 1'b0;
    dstl_d   = 1'b0;
    addrm_d  = 2'd0;
    addrl_d  = 1'b0;
    idxm_d   = 1'b0;
    pcinc_d  = 1'b0;
    reginc_d = 1'b0;
    incsel_d = 4'd0;
    incamt_d = 2'd0;

    case (state_d)
      StSrcExt: begin
        rdst_d  = PC_REG;
        rsrc_d  = src_base;
        addrm_d = 2'd3;
        addrl_d = 1'b1;
        pcinc_d = 1'b1;
      end
      StSrcRd: begin
        srcm_d = 1'b1;
        srcl_d = 1'b1;
      end
      StSrcInd: begin
        addrm_d = 2'd2;
        srcm_d  = 1'b1;
        srcl_d  = 1'b1;
        if (as_d == 2'b11) begin
          if (rs_d == PC_REG) begin
            pcinc_d = 1'b1;
          end else begin
            reginc_d = 1'b1;
            incsel_d = rs_d;
            incamt_d = (bw_d && (rs_d > 4'd1)) ? 2'd1 : 2'd2;
          end
        end
      end
      StDstExt: begin
        rsrc_d  = PC_REG;
        rdst_d  = dst_base;
        addrm_d = 2'd2;
        idxm_d  = 1'b1;
        addrl_d = 1'b1;
        pcinc_d = 1'b1;
      end
      StDstRd: begin
        dstm_d = 1'b1;
        dstl_d = 1'b1;
      end
      StDstInd: begin
        addrm_d = 2'd3;
        addrl_d = 1'b1;
        dstm_d  = 1'b1;
        dstl_d  = 1'b1;
        if (as_d == 2'b11) begin
          if (rd_d == PC_REG) begin
            pcinc_d = 1'b1;
          end else begin
            reginc_d = 1'b1;
            incsel_d = rd_d;
            incamt_d = (bw_d && (rd_d > 4'd1)) ? 2'd1 : 2'd2;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      fmt_q    <= 2'd0;
      as_q     <= 2'd0;
      ad_q     <= 1'b0;
      bw_q     <= 1'b0;
      rs_q     <= 4'd0;
      rd_q     <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rsrc_q   <= 4'd0;
      rdst_q   <= 4'd0;
      srcm_q   <= 1'b0;
      srcl_q   <= 1'b0;
      dstm_q   <= 1'b0;
      dstl_q   <= 1'b0;
      addrm_q  <= 2'd0;
      addrl_q  <= 1'b0;
      idxm_q   <= 1'b0;
      pcinc_q  <= 1'b0;
      reginc_q <= 1'b0;
      incsel_q <= 4'd0;
      incamt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      fmt_q    <= fmt_d;
      as_q     <= as_d;
      ad_q     <= ad_d;
      bw_q     <= bw_d;
      rs_q     <= rs_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rsrc_q   <= rsrc_d;
      rdst_q   <= rdst_d;
      srcm_q   <= srcm_d;
      srcl_q   <= srcl_d;
      dstm_q   <= dstm_d;
      dstl_q   <= dstl_d;
      addrm_q  <= addrm_d;
      addrl_q  <= addrl_d;
      idxm_q   <= idxm_d;
      pcinc_q  <= pcinc_d;
      reginc_q <= reginc_d;
      incsel_q <= incsel_d;
      incamt_q <= incamt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rsrc_sel = rsrc_q;
  assign rdst_sel = rdst_q;
  assign srcM     = srcm_q;
  assign srcL     = srcl_q;
  assign dstM     = dstm_q;
  assign dstL     = dstl_q;
  assign AddrM    = addrm_q;
  assign AddrL    = addrl_q;
  assign IdxM     = idxm_q;
  assign pc_inc   = pcinc_q;
  assign reg_inc  = reginc_q;
  assign inc_sel  = incsel_q;
  assign inc_amt  = incamt_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: per-cycle expected control vectors are queued by
// the stimulus and popped by a monitor on every busy cycle plus the first idle cycle after.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] fmt = 2'd0, As = 2'd0;
  logic       Ad = 1'b0, BW = 1'b0;
  logic [3:0] Rs = 4'd0, Rd = 4'd0;
  logic       busy, done, srcM, srcL, dstM, dstL, AddrL, IdxM, pc_inc, reg_inc;
  logic [3:0] rsrc_sel, rdst_sel, inc_sel;
  logic [1:0] AddrM, inc_amt;

  operand_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .fmt(fmt), .As(As), .Ad(Ad), .BW(BW),
    .Rs(Rs), .Rd(Rd), .busy(busy), .done(done), .rsrc_sel(rsrc_sel), .rdst_sel(rdst_sel),
    .srcM(srcM), .srcL(srcL), .dstM(dstM), .dstL(dstL), .AddrM(AddrM), .AddrL(AddrL),
    .IdxM(IdxM), .pc_inc(pc_inc), .reg_inc(reg_inc), .inc_sel(inc_sel), .inc_amt(inc_amt)
  );

  always #5 clk = ~clk;

  // {busy,done,rsrc,rdst,srcM,srcL,dstM,dstL,AddrM,AddrL,IdxM,pc_inc,reg_inc,inc_sel,inc_amt}
  logic [25:0] act;
  assign act = {busy, done, rsrc_sel, rdst_sel, srcM, srcL, dstM, dstL, AddrM, AddrL, IdxM,
                pc_inc, reg_inc, inc_sel, inc_amt};

  int          n_checks = 0;
  int          n_fail = 0;
  logic [25:0] exp_q[$];
  string       tag_q[$];
  logic        mon_prev_busy = 1'b0;
  logic [25:0] mon_v;
  string       mon_t;

  function automatic logic [25:0] ev(input logic b, input logic d, input logic [3:0] rs,
      input logic [3:0] rd, input logic sm, input logic sl, input logic dm, input logic dl,
      input logic [1:0] am, input logic al, input logic im, input logic pi, input logic ri,
      input logic [3:0] is, input logic [1:0] ia);
    return {b, d, rs, rd, sm, sl, dm, dl, am, al, im, pi, ri, is, ia};
  endfunction

  task automatic check(input string name, input logic [25:0] got, input logic [25:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [25:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (busy || mon_prev_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: actual %h required none", act);
      end else begin
        mon_v = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        check(mon_t, act, mon_v);
      end
    end
    mon_prev_busy <= busy;
  end

  task automatic launch(input logic [1:0] f, input logic [1:0] a, input logic d,
                        input logic b, input logic [3:0] s, input logic [3:0] r);
    @(posedge clk); #1;
    fmt = f; As = a; Ad = d; BW = b; Rs = s; Rd = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: actual busy=1 required busy=0 within 20 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #2 check("reset_async", act, 26'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 check("reset_idle", act, 26'd0);

    // MOV R5,R6
    push("mov_rr_done", ev(1,1, 5,6, 0,0,0,0, 0,0,0,0,0, 0,0));
    push("mov_rr_idle", ev(0,0, 5,6, 0,0,0,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b00, 1'b0, 1'b0, 4'd5, 4'd6);
    wait_idle("mov_rr");

    // ADD 4(R5),2(R6) with a start pulse during SRC_RD that must be ignored
    push("add_src_ext", ev(1,0, 5,0, 0,0,0,0, 3,1,0,1,0, 0,0));
    push("add_src_rd",  ev(1,0, 5,6, 1,1,0,0, 0,0,0,0,0, 0,0));
    push("add_dst_ext", ev(1,0, 0,6, 1,0,0,0, 2,1,1,1,0, 0,0));
    push("add_dst_rd",  ev(1,0, 5,6, 1,0,1,1, 0,0,0,0,0, 0,0));
    push("add_done",    ev(1,1, 5,6, 1,0,1,0, 0,0,0,0,0, 0,0));
    push("add_idle",    ev(0,0, 5,6, 1,0,1,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b01, 1'b1, 1'b0, 4'd5, 4'd6);
    @(posedge clk); #1;
    fmt = 2'b10; As = 2'b00; Ad = 1'b0; Rs = 4'd9; Rd = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("add_idx_idx");

    // MOV.B @R7+,R8 / MOV @R7+,R8 / MOV.B @SP+,R8
    push("movb_ind", ev(1,0, 7,8, 1,1,0,0, 2,0,0,0,1, 7,1));
    push("movb_done", ev(1,1, 7,8, 1,0,0,0, 0,0,0,0,0, 0,0));
    push("movb_idle", ev(0,0, 7,8, 1,0,0,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b11, 1'b0, 1'b1, 4'd7, 4'd8);
    wait_idle("movb_autoinc");
    push("movw_ind", ev(1,0, 7,8, 1,1,0,0, 2,0,0,0,1, 7,2));
    push("movw_done", ev(1,1, 7,8, 1,0,0,0, 0,0,0,0,0, 0,0));
    push("movw_idle", ev(0,0, 7,8, 1,0,0,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b11, 1'b0, 1'b0, 4'd7, 4'd8);
    wait_idle("movw_autoinc");
    push("movb_sp_ind", ev(1,0, 1,8, 1,1,0,0, 2,0,0,0,1, 1,2));
    push("movb_sp_done", ev(1,1, 1,8, 1,0,0,0, 0,0,0,0,0, 0,0));
    push("movb_sp_idle", ev(0,0, 1,8, 1,0,0,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b11, 1'b0, 1'b1, 4'd1, 4'd8);
    wait_idle("movb_sp");

    // MOV #0x1234,&0x0200
    push("imm_src_ind", ev(1,0, 0,2, 1,1,0,0, 2,0,0,1,0, 0,0));
    push("abs_dst_ext", ev(1,0, 0,3, 1,0,0,0, 2,1,1,1,0, 0,0));
    push("abs_dst_rd",  ev(1,0, 0,2, 1,0,1,1, 0,0,0,0,0, 0,0));
    push("imm_abs_done", ev(1,1, 0,2, 1,0,1,0, 0,0,0,0,0, 0,0));
    push("imm_abs_idle", ev(0,0, 0,2, 1,0,1,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b11, 1'b1, 1'b0, 4'd0, 4'd2);
    wait_idle("imm_abs");

    // Constant generator R3 with As=11, then a jump
    push("cg_done", ev(1,1, 3,9, 0,0,0,0, 0,0,0,0,0, 0,0));
    push("cg_idle", ev(0,0, 3,9, 0,0,0,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b11, 1'b0, 1'b0, 4'd3, 4'd9);
    wait_idle("cg");
    push("jmp_done", ev(1,1, 4,5, 0,0,0,0, 0,0,0,0,0, 0,0));
    push("jmp_idle", ev(0,0, 4,5, 0,0,0,0, 0,0,0,0,0, 0,0));
    launch(2'b10, 2'b01, 1'b1, 1'b0, 4'd4, 4'd5);
    wait_idle("jmp");

    // Single-operand RRC @R9+, then RRC &addr
    push("so_ind", ev(1,0, 4,9, 0,0,1,1, 3,1,0,0,1, 9,2));
    push("so_ind_done", ev(1,1, 4,9, 0,0,1,0, 0,0,0,0,0, 0,0));
    push("so_ind_idle", ev(0,0, 4,9, 0,0,1,0, 0,0,0,0,0, 0,0));
    launch(2'b01, 2'b11, 1'b0, 1'b0, 4'd4, 4'd9);
    wait_idle("so_autoinc");
    push("so_abs_ext", ev(1,0, 0,3, 0,0,0,0, 2,1,1,1,0, 0,0));
    push("so_abs_rd",  ev(1,0, 4,2, 0,0,1,1, 0,0,0,0,0, 0,0));
    push("so_abs_done", ev(1,1, 4,2, 0,0,1,0, 0,0,0,0,0, 0,0));
    push("so_abs_idle", ev(0,0, 4,2, 0,0,1,0, 0,0,0,0,0, 0,0));
    launch(2'b01, 2'b01, 1'b0, 1'b0, 4'd4, 4'd2);
    wait_idle("so_abs");

    // Reset asserted between edges while in DST_EXT
    push("abort_src_ext", ev(1,0, 5,0, 0,0,0,0, 3,1,0,1,0, 0,0));
    push("abort_src_rd",  ev(1,0, 5,6, 1,1,0,0, 0,0,0,0,0, 0,0));
    push("abort_dst_ext", ev(1,0, 0,6, 1,0,0,0, 2,1,1,1,0, 0,0));
    push("abort_after",   26'd0);
    launch(2'b00, 2'b01, 1'b1, 1'b0, 4'd5, 4'd6);
    @(posedge clk); #1;
    @(posedge clk); #7;
    rst = 1'b1;
    #1 check("abort_async", act, 26'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;

    // Recovery after abort
    push("post_rst_done", ev(1,1, 5,6, 0,0,0,0, 0,0,0,0,0, 0,0));
    push("post_rst_idle", ev(0,0, 5,6, 0,0,0,0, 0,0,0,0,0, 0,0));
    launch(2'b00, 2'b00, 1'b0, 1'b0, 4'd5, 4'd6);
    wait_idle("post_rst");

    @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
